riscv_mem_arbiter: RTL and testbench
====================================

# riscv_mem_arbiter

Two-requester arbiter that shares one single-ported instruction/data memory between the `riscv_pipeline` fetch stage and its MEM stage. It sequences each access through a fixed-latency memory, returns read data to the winning requester, and suppresses stale fetch responses after a pipeline redirect. It sits between the pipeline core and the memory model.

## Interface
- `MEM_LAT`, default 2: cycles from `mem_en` until `mem_rdata` is valid; legal range is 1..8.
- `MAX_DSTREAK`, default 2: the number of consecutive data grants allowed while a fetch is waiting.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_flush`  in  1  pipeline redirect; discards any outstanding fetch response.
- `if_gnt`  out  1  one-cycle grant pulse to fetch.
- `if_rvalid`  out  1  one-cycle fetch-data-valid pulse.
- `if_rdata`  out  32  fetched word.
- `d_req`  in  1  data request; held with its payload until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_wstrb`  in  4  store byte enables.
- `d_gnt`  out  1  one-cycle grant pulse to data.
- `d_rvalid`  out  1  one-cycle completion pulse for loads and stores.
- `d_rdata`  out  32  load word.
- `mem_en`, `mem_we`  out  1  memory strobe and write enable.
- `mem_addr`, `mem_wdata`  out  32  memory address and write data.
- `mem_wstrb`  out  4  memory byte enables.
- `mem_rdata`  in  32  memory read data.
- `busy`  out  1  high while an access is outstanding.

## Operation
- **State machine**
  - IDLE → ACCESS when a grant is issued.
  - ACCESS → RESP when the latency counter reaches `MEM_LAT`-1.
  - RESP → IDLE unconditionally.
- **Grant in IDLE (combinational, same cycle)**
  - Data has priority, unless `dstreak == MAX_DSTREAK` and `if_req` is high; then fetch wins.
  - Exactly one of `if_gnt` / `d_gnt` is high, and `mem_en` is high in that same cycle.
  - `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are driven from the winner.
  - For a fetch grant: `mem_we` = 0 and `mem_wstrb` = 0.
- **Owner and counters**
  - On grant, the owner (fetch or data) is registered.
  - The latency counter (`$clog2(MEM_LAT+1)` bits) is cleared, then increments each ACCESS cycle.
- **dstreak**
  - Increments on a data grant while `if_req` is high; saturates at `MAX_DSTREAK`.
  - Clears on a fetch grant.
  - Clears on a data grant with `if_req` low.
- **Read capture**
  - `mem_rdata` is sampled on the edge ending cycle T+`MEM_LAT`.
  - It is presented registered during RESP, with the owner's `rvalid` high.
  - `rdata` holds its value until the next capture for that owner.
- **Stores**: `d_rvalid` pulses in RESP; `d_rdata` is unchanged.
- **`if_flush`**
  - If high in any cycle while fetch owns an access, or in the grant cycle itself, a `drop` flag is set.
  - When `drop` is set, `if_rvalid` is suppressed in RESP.
  - `drop` clears on the next IDLE grant.
  - Flush has no effect on data accesses or on ungranted requests.
- **`busy`**: high in ACCESS and RESP.
- **Reset**
  - Asynchronous: the state machine returns to IDLE and counters, `dstreak`, `drop` and `rdata` go to 0.
  - All outputs read 0 during reset; grants and `mem_en` are gated off even if `req` is high.
  - An access in flight is abandoned with no `rvalid`.

## Timing
- Grant cycle T: `gnt` = 1 and `mem_en` = 1 (memory samples at the end of T).
- ACCESS occupies T+1..T+`MEM_LAT`.
- RESP is cycle T+`MEM_LAT`+1: `rvalid` = 1 and `rdata` is valid.
- The earliest next grant is cycle T+`MEM_LAT`+2, giving one access per `MEM_LAT`+2 cycles (4 cycles at default).
- With `MEM_LAT` = 1 there is one ACCESS cycle.
- `req` dropped before `gnt`: the request is withdrawn legally. Asserting `req` never forces a grant outside IDLE.
- Simultaneous `if_req` and `d_req` in IDLE: resolved only by the priority/`dstreak` rule; no grant is lost or duplicated.
- `if_flush` coinciding with RESP of a fetch: `if_rvalid` = 0 that cycle.

## Test plan
- **Reset**
  - Hold `reset` = 0 for 5 cycles with `if_req` = `d_req` = 1.
  - Required: every output 0 and no `mem_en`.
  - Release `reset`: `d_gnt` in the first IDLE cycle.
- **Single fetch**
  - `if_req`, `if_addr` = 0x14, memory returns 0x00400393.
  - Required: `if_gnt`/`mem_en` at T, `if_rvalid` = 1 with `if_rdata` = 0x00400393 at T+3, `busy` high T+1..T+3.
- **Load and store**
  - Store `d_addr` = 0x8, `d_wdata` = 0xFEDCBA98, `d_wstrb` = 0xF. Required: `mem_we` = 1 at grant, `d_rvalid` pulse at T+3.
  - Then load from 0x8. Required: `d_rdata` = 0xFEDCBA98.
- **Contention and starvation**
  - `if_req` and `d_req` held high continuously.
  - Required grant sequence: D, D, F, D, D, F with `MAX_DSTREAK` = 2, spaced 4 cycles apart.
- **Flush**
  - Fetch of 0x34 granted; `if_flush` pulsed in cycle T+1.
  - Required: no `if_rvalid` at T+3; the next fetch returns data normally.
- **Reset mid-access**
  - Assert `reset` in ACCESS of a load from 0xC.
  - Required: no `d_rvalid` ever for that load, and the state machine is in IDLE after release.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Shares one fixed-latency memory between fetch and data: grant in the same cycle, response MEM_LAT+1 cycles later.
// Latency MEM_LAT+1 cycles from grant to rvalid; requests wait while busy, with a data-streak cap so fetch cannot starve.
// Backpressure: requesters hold req until their gnt pulse; no grant is issued outside IDLE or during reset.
module riscv_mem_arbiter #(
    parameter int MEM_LAT     = 2,
    parameter int MAX_DSTREAK = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int SW = (MAX_DSTREAK < 2) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          owner_f_q, owner_f_d;
    logic          store_q, store_d;
    logic          drop_q, drop_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          starve;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            owner_f_q  <= 1'b0;
            store_q    <= 1'b0;
            drop_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            owner_f_q  <= owner_f_d;
            store_q    <= store_d;
            drop_q     <= drop_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign starve = (streak_q == STREAK_MAX) && if_req;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        owner_f_d  = owner_f_q;
        store_d    = store_q;
        drop_d     = drop_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;

        unique case (state_q)
            IDLE: begin
                // Reset gates grants combinationally so nothing leaks while reset is held.
                if (reset) begin
                    d_gnt  = d_req && !starve;
                    if_gnt = if_req && !d_gnt;
                end
                if (d_gnt || if_gnt) begin
                    mem_en    = 1'b1;
                    state_d   = ACCESS;
                    cnt_d     = '0;
                    owner_f_d = if_gnt;
                    store_d   = d_gnt && d_we;
                    drop_d    = if_gnt && if_flush;
                end
                if (d_gnt) begin
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    mem_wstrb = d_wstrb;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
                if (if_gnt) begin
                    mem_addr = if_addr;
                    streak_d = '0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (owner_f_q && if_flush) begin
                    drop_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    if (owner_f_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!store_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d   = IDLE;
                if_rvalid = owner_f_q && !drop_q && !if_flush;
                d_rvalid  = !owner_f_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: timestamp-based reference model plus memory model, directed scenarios then random traffic.
module tb_riscv_mem_arbiter;
    localparam int MEM_LAT = 2;
    localparam int MAXD    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wstrb;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    riscv_mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory contents and model state: an access is described by its grant cycle, not by FSM states.
    logic [31:0] mem [64];
    int          cyc = 0;
    bit          m_active = 0;
    int          m_t = 0;
    bit          m_fetch, m_store, m_drop;
    int          m_streak = 0;
    logic [31:0] m_word;
    logic [31:0] m_if_rdata = '0, m_d_rdata = '0;

    // Observation logs used by the directed checks.
    bit          seen_if_gnt = 0, seen_d_gnt = 0;
    int          last_if_gnt = 0, last_if_rv = 0, last_d_gnt = 0, last_d_rv = 0;
    logic [31:0] last_if_dat = '0;
    logic        last_d_we = 1'b0;
    int          if_rv_cnt = 0, d_rv_cnt = 0, en_in_rst = 0;
    bit          gseq[$];
    int          gcyc[$];

    always @(negedge clk) begin : compare
        logic        e_ifg, e_dg, e_en, e_we, e_ifrv, e_drv, e_busy, dwin, fwin;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_ws;
        int          ph, idx;
        e_ifg = 0; e_dg = 0; e_en = 0; e_we = 0; e_ifrv = 0; e_drv = 0; e_busy = 0;
        e_addr = '0; e_wd = '0; e_ws = '0;
        if (!reset) begin
            m_active = 0; m_streak = 0; m_drop = 0; m_if_rdata = '0; m_d_rdata = '0;
        end else if (!m_active) begin
            dwin = d_req && !(m_streak == MAXD && if_req);
            fwin = if_req && !dwin;
            e_dg = dwin; e_ifg = fwin; e_en = dwin || fwin;
            if (dwin) begin
                e_we = d_we; e_addr = d_addr; e_wd = d_wdata; e_ws = d_wstrb;
                m_streak = if_req ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
            end
            if (fwin) begin
                e_addr = if_addr;
                m_streak = 0;
            end
            if (e_en) begin
                m_active = 1; m_t = cyc; m_fetch = fwin; m_store = dwin && d_we;
                m_drop = fwin && if_flush;
                idx = int'(e_addr[7:2]);
                m_word = mem[idx];
                if (m_store)
                    for (int b = 0; b < 4; b++)
                        if (d_wstrb[b]) mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
            end
        end else begin
            ph = cyc - m_t;
            e_busy = 1;
            if (ph == MEM_LAT + 1) begin
                e_ifrv = m_fetch && !m_drop && !if_flush;
                e_drv  = !m_fetch;
            end
        end

        chk("if_gnt", if_gnt, e_ifg);
        chk("d_gnt", d_gnt, e_dg);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_wstrb", mem_wstrb, e_ws);
        chk("busy", busy, e_busy);
        chk("if_rvalid", if_rvalid, e_ifrv);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("d_rdata", d_rdata, m_d_rdata);
        if (e_ifrv) chk("if_rdata", if_rdata, m_if_rdata);
        if (!reset) chk("if_rdata_rst", if_rdata, 32'h0);

        // Post-compare model advance: flush marks, read capture and end of response.
        if (reset && m_active && cyc != m_t) begin
            ph = cyc - m_t;
            if (m_fetch && if_flush) m_drop = 1;
            if (ph == MEM_LAT) begin
                if (m_fetch) m_if_rdata = m_word;
                else if (!m_store) m_d_rdata = m_word;
            end
            if (ph == MEM_LAT + 1) m_active = 0;
        end

        seen_if_gnt = if_gnt; seen_d_gnt = d_gnt;
        if (if_gnt) begin last_if_gnt = cyc; gseq.push_back(1'b1); gcyc.push_back(cyc); end
        if (d_gnt) begin last_d_gnt = cyc; last_d_we = mem_we; gseq.push_back(1'b0); gcyc.push_back(cyc); end
        if (if_rvalid) begin last_if_rv = cyc; last_if_dat = if_rdata; if_rv_cnt++; end
        if (d_rvalid) begin last_d_rv = cyc; d_rv_cnt++; end
        if (!reset && mem_en) en_in_rst++;

        // Memory presents read data only for the edge that ends cycle T+MEM_LAT.
        if (m_active && cyc == m_t + MEM_LAT) mem_rdata = m_word;
        else mem_rdata = $urandom;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_f(input logic [31:0] a);
        int n = 0;
        if_req = 1; if_addr = a;
        do begin tick(); n++; end while (!seen_if_gnt && n < 20);
        chk("f_gnt_wait", seen_if_gnt, 1);
        if_req = 0;
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        int n = 0;
        d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
        do begin tick(); n++; end while (!seen_d_gnt && n < 20);
        chk("d_gnt_wait", seen_d_gnt, 1);
        d_req = 0;
    endtask

    initial begin
        int gstart, rv0, drv0;
        bit exp_seq [6];
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
        mem[5] = 32'h0040_0393;
        mem_rdata = '0;
        reset = 0; if_flush = 0; d_we = 0; d_wdata = '0; d_wstrb = '0;
        if_req = 1; d_req = 1; if_addr = 32'h0; d_addr = 32'h0;

        // Reset with both requests high, then release: data wins first.
        repeat (5) tick();
        chk("rst_no_mem_en", 32'(en_in_rst), 0);
        reset = 1;
        tick();
        chk("rel_d_first", seen_d_gnt, 1);
        chk("rel_no_f", seen_if_gnt, 0);
        if_req = 0; d_req = 0;
        repeat (6) tick();

        issue_f(32'h14);
        repeat (5) tick();
        chk("f_lat", 32'(last_if_rv - last_if_gnt), 32'(MEM_LAT + 1));
        chk("f_data", last_if_dat, 32'h0040_0393);

        issue_d(1, 32'h8, 32'hFEDC_BA98, 4'hF);
        repeat (5) tick();
        chk("st_we", last_d_we, 1);
        chk("st_lat", 32'(last_d_rv - last_d_gnt), 32'(MEM_LAT + 1));
        issue_d(0, 32'h8, 32'h0, 4'h0);
        repeat (5) tick();
        chk("ld_data", d_rdata, 32'hFEDC_BA98);

        // Contention: both held high continuously.
        gstart = gseq.size();
        if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h4;
        repeat (24) tick();
        if_req = 0; d_req = 0;
        repeat (6) tick();
        chk("cont_count", 32'(gseq.size() - gstart), 6);
        if (gseq.size() >= gstart + 6)
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("cont_seq%0d", i), gseq[gstart + i], exp_seq[i]);
                if (i > 0) chk($sformatf("cont_gap%0d", i), 32'(gcyc[gstart + i] - gcyc[gstart + i - 1]), 32'(MEM_LAT + 2));
            end

        // Flush in T+1 kills the fetch response; the next fetch is normal.
        rv0 = if_rv_cnt;
        issue_f(32'h34);
        if_flush = 1;
        tick();
        if_flush = 0;
        repeat (5) tick();
        chk("flush_no_rv", 32'(if_rv_cnt), 32'(rv0));
        issue_f(32'h14);
        repeat (5) tick();
        chk("flush_next_rv", 32'(if_rv_cnt), 32'(rv0 + 1));
        chk("flush_next_data", last_if_dat, 32'h0040_0393);

        // Reset during ACCESS of a load abandons it.
        drv0 = d_rv_cnt;
        issue_d(0, 32'hC, 32'h0, 4'h0);
        reset = 0;
        tick();
        reset = 1;
        repeat (6) tick();
        chk("rst_mid_no_rv", 32'(d_rv_cnt), 32'(drv0));
        chk("rst_mid_idle", busy, 0);

        // Randomized traffic with legal hold/withdraw behaviour.
        for (int i = 0; i < 3000; i++) begin
            if (!(if_req && !seen_if_gnt && $urandom_range(9) != 0)) begin
                if_req  = 1'($urandom_range(1));
                if_addr = {24'h0, 6'($urandom_range(63)), 2'b00};
            end
            if (!(d_req && !seen_d_gnt && $urandom_range(9) != 0)) begin
                d_req   = 1'($urandom_range(1));
                d_we    = 1'($urandom_range(1));
                d_addr  = {24'h0, 6'($urandom_range(63)), 2'b00};
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(15));
            end
            if_flush = ($urandom_range(7) == 0);
            tick();
        end
        if_req = 0; d_req = 0; if_flush = 0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
